// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared constants and types for the CNN pixel server.
//               Provides the server FSM state encoding, the default image
//               geometry and the decision code that reports a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int PIXEL_BITS = 8;
    localparam int IMG_PIXELS = 784;

    // Decision reported when the CNN never answers (timeout build only)
    localparam logic [3:0] DECISION_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        LOAD        = 2'd0,
        SERVE       = 2'd1,
        WAIT_RESULT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_pixel_ram.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pixel_ram
// Description : Single-port pixel store, synchronous write, registered read
//               (read-before-write). Written to map onto a block RAM, so the
//               array has no reset.
// Ports       : clk   - clock
//               we    - write enable
//               addr  - shared read/write address
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_pixel_ram #(
    parameter int DATA_BITS = cnn_pkg::PIXEL_BITS,
    parameter int DEPTH     = cnn_pkg::IMG_PIXELS,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/cnn_pixel_server.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pixel_server
// Description : Pixel source for the CNN top. Loads one image from a
//               valid/ready byte stream while holding the CNN in reset,
//               then releases the CNN and serves pixels by index. The CNN's
//               decision is captured and the block re-arms for the next image.
//               Optional macro PIXEL_SERVER_TIMEOUT_EN adds a watchdog in
//               WAIT_RESULT that reports DECISION_TIMEOUT after
//               TIMEOUT_CYCLES cycles without an answer.
// Ports       : clk, rst (sync, active high)
//               wr_valid/wr_ready/wr_data - image load stream
//               cnn_rst_n                 - CNN reset, low while loading
//               rd_idx/rd_data            - pixel fetch (1-cycle latency)
//               infer_done/decision_in    - CNN result handshake
//               result/result_valid       - captured decision + 1-cycle pulse
//               busy                      - high in SERVE and WAIT_RESULT
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_pixel_server #(
    parameter int PIXEL_BITS     = cnn_pkg::PIXEL_BITS,
    parameter int IMG_PIXELS     = cnn_pkg::IMG_PIXELS,
    parameter int IDX_BITS       = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PIXEL_BITS-1:0] wr_data,
    output logic                  cnn_rst_n,
    input  logic [IDX_BITS-1:0]   rd_idx,
    output logic [PIXEL_BITS-1:0] rd_data,
    input  logic                  infer_done,
    input  logic [3:0]            decision_in,
    output logic [3:0]            result,
    output logic                  result_valid,
    output logic                  busy
);

    import cnn_pkg::*;

    localparam logic [IDX_BITS-1:0] C_LAST_IDX = IDX_BITS'(IMG_PIXELS - 1);
    localparam logic [IDX_BITS-1:0] C_NUM_PIX  = IDX_BITS'(IMG_PIXELS);

    generate
        if (TIMEOUT_CYCLES < 1 || IMG_PIXELS > (1 << IDX_BITS)) begin : g_bad_params
            $error("cnn_pixel_server: inconsistent parameters");
        end
    endgenerate

    state_t                r_state, w_state_next;
    logic [IDX_BITS-1:0]   r_wr_ptr, w_wr_ptr_next;
    logic                  r_wr_ready, w_wr_ready_next;
    logic                  r_cnn_rst_n, w_cnn_rst_n_next;
    logic [3:0]            r_result, w_result_next;
    logic                  r_result_valid, w_result_valid_next;
    logic                  r_rd_zero;
    logic                  w_serving, w_rd_in_range, w_wr_fire, w_wd_expire;
    logic [IDX_BITS-1:0]   w_ram_addr;
    logic [PIXEL_BITS-1:0] w_ram_rdata;

    assign w_serving     = (r_state != LOAD);
    assign w_rd_in_range = (rd_idx < C_NUM_PIX);
    assign w_wr_fire     = wr_valid && r_wr_ready && (r_state == LOAD);

    // One RAM port: the write pointer owns it while loading, the CNN after.
    // Out-of-range indices are steered to 0 so the array is never overrun;
    // their data is masked by r_rd_zero anyway.
    assign w_ram_addr = w_serving ? (w_rd_in_range ? rd_idx : '0) : r_wr_ptr;

    cnn_pixel_ram #(
        .DATA_BITS (PIXEL_BITS),
        .DEPTH     (IMG_PIXELS),
        .ADDR_BITS (IDX_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_fire),
        .addr  (w_ram_addr),
        .wdata (wr_data),
        .rdata (w_ram_rdata)
    );

`ifdef PIXEL_SERVER_TIMEOUT_EN
    localparam int C_WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_WD_BITS-1:0] r_wd_cnt;

    // Counts cycles spent in WAIT_RESULT; restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != WAIT_RESULT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expire = (r_state == WAIT_RESULT) &&
                         (r_wd_cnt == C_WD_BITS'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        w_state_next        = r_state;
        w_wr_ptr_next       = r_wr_ptr;
        w_wr_ready_next     = r_wr_ready;
        w_cnn_rst_n_next    = r_cnn_rst_n;
        w_result_next       = r_result;
        w_result_valid_next = 1'b0;
        case (r_state)
            LOAD: begin
                w_wr_ready_next = 1'b1;
                if (w_wr_fire) begin
                    if (r_wr_ptr == C_LAST_IDX) begin
                        w_state_next     = SERVE;
                        w_wr_ptr_next    = '0;
                        w_wr_ready_next  = 1'b0;
                        w_cnn_rst_n_next = 1'b1;
                    end else begin
                        w_wr_ptr_next = r_wr_ptr + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (rd_idx == C_LAST_IDX) begin
                    w_state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                // A real decision beats a watchdog expiry in the same cycle.
                if (infer_done || w_wd_expire) begin
                    w_result_next       = infer_done ? decision_in : DECISION_TIMEOUT;
                    w_result_valid_next = 1'b1;
                    w_cnn_rst_n_next    = 1'b0;
                    w_wr_ready_next     = 1'b1;
                    w_state_next        = LOAD;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= LOAD;
            r_wr_ptr       <= '0;
            r_wr_ready     <= 1'b0;
            r_cnn_rst_n    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_rd_zero      <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_wr_ptr       <= w_wr_ptr_next;
            r_wr_ready     <= w_wr_ready_next;
            r_cnn_rst_n    <= w_cnn_rst_n_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            // Aligned with the RAM's registered read: forces the pixel to 0
            // while loading or when the index is past the image.
            r_rd_zero      <= !w_serving || !w_rd_in_range;
        end
    end

    assign wr_ready     = r_wr_ready;
    assign cnn_rst_n    = r_cnn_rst_n;
    assign rd_data      = r_rd_zero ? '0 : w_ram_rdata;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = w_serving;

endmodule
`default_nettype wire
